// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one execute-stage result per cycle onto the registered common data bus.
// Latency: a result acked in cycle N is broadcast on cdb_* in cycle N+1; req_ack is combinational.
// Backpressure: cdb_ready=0 with a pending broadcast freezes the bus and withholds every req_ack.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous flush: drops the broadcast, restarts the scan at index 0
//   req_valid/tag/data  per-requester result (index NUM_REQ-1 is the branch unit)
//   req_ack         one-hot-or-zero consume strobe back to the requesters
//   cdb_ready       ROB accepts the current broadcast
//   cdb_valid/tag/data/src  registered broadcast
//
// Optional feature: define CDB_ARB_BR_PRIORITY_EN to let the branch unit win unconditionally.
module cdb_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int TAG_W = 3,
  parameter int DATA_W = 32,
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [SRC_W-1:0]  rr_ptr;
  logic              load_en;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic              br_prio;
  logic [SRC_W:0]    scan_sum;
  logic [SRC_W-1:0]  scan_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  // The bus register can take a new value when it is empty or being drained this cycle.
  assign load_en = ~flush & (~cdb_valid | cdb_ready);

  // Scan from rr_ptr, wrapping at NUM_REQ rather than at 2^SRC_W. One extra
  // bit on the sum holds rr_ptr + k before the single conditional subtract.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    br_prio     = 1'b0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
`ifdef CDB_ARB_BR_PRIORITY_EN
    // Branch results resolve mispredicts, so they bypass the rotation and
    // leave the pointer where the reservation stations expect it.
    if (req_valid[NUM_REQ-1]) begin
      grant_found = 1'b1;
      grant_idx   = SRC_W'(NUM_REQ-1);
      br_prio     = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Gated by rst so nothing is consumed while the bus register is held clear.
  assign req_ack = (load_en && grant_found && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= sel_tag;
        cdb_data  <= sel_data;
        cdb_src   <= grant_idx;
        if (!br_prio) begin
          rr_ptr <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the single common data bus (CDB). It takes completed results from the four ALU reservation-station functional units and the branch unit, grants one per cycle, and registers the winner onto the CDB. The ROB, the register file and the reservation stations snoop the registered bus. It sits between the execute stage and the ROB write port, and applies backpressure to losing requesters through a per-requester acknowledge.

## Interface
Parameters:
- NUM_REQ, 5, number of requesters; index NUM_REQ-1 is the branch unit, indices 0..NUM_REQ-2 are reservation stations res1..res4.
- TAG_W, 3, ROB tag width.
- DATA_W, 32, result width.
- SRC_W, $clog2(NUM_REQ), width of the granted-source index (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch mispredict).
- req_valid  in  NUM_REQ  requester i holds a result.
- req_tag  in  NUM_REQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot or zero; requester i is consumed this cycle (yumi-style).
- cdb_ready  in  1  ROB can accept a broadcast this cycle.
- cdb_valid  out  1  CDB holds a valid broadcast.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_data  out  DATA_W  broadcast result.
- cdb_src  out  SRC_W  index of the requester that produced the broadcast.

## Operation
- State:
  - output register {cdb_valid, cdb_tag, cdb_data, cdb_src};
  - round-robin pointer rr_ptr (SRC_W bits, range 0..NUM_REQ-1).
- load_en = ~flush & (~cdb_valid | cdb_ready).
- Arbitration when load_en = 1:
  - Scan i = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ (not 2^SRC_W).
  - The first i with req_valid[i]=1 is the grant g.
- On a grant:
  - req_ack[g]=1;
  - output register loads req_tag/req_data slice g, cdb_src=g, cdb_valid=1;
  - rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1.
- load_en = 1 with no req_valid:
  - req_ack=0; cdb_valid <= 0; rr_ptr unchanged.
  - Tag, data and src hold their old values (don't-care).
- load_en = 0 and no flush (stall: cdb_valid=1, cdb_ready=0):
  - output register holds all fields stable;
  - req_ack=0; rr_ptr unchanged.
- flush:
  - cdb_valid <= 0; rr_ptr <= 0; req_ack=0 in the flush cycle;
  - a pending broadcast is dropped even if cdb_ready=1.
- Requesters must hold req_valid, req_tag and req_data stable until acked. The arbiter never acks a requester whose req_valid=0.
- Reset (async, rst=1): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0. req_ack=0 while rst=1.

## Timing
- req_ack is combinational from req_valid, rr_ptr, cdb_valid, cdb_ready and flush, within the same cycle.
- No combinational path from req_* to the cdb_* outputs; all cdb_* outputs are registered.
- Latency: a request acked in cycle N appears on the CDB in cycle N+1.
- Throughput: one broadcast per cycle while cdb_ready=1. A simultaneous drain and load is allowed (back-to-back grants).
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ grants.
- A reset asserted mid-broadcast clears cdb_valid immediately (asynchronously), with no ack in that cycle.

## Configuration
- CDB_ARB_BR_PRIORITY_EN defined:
  - req_valid[NUM_REQ-1] (branch) wins unconditionally whenever load_en=1;
  - rr_ptr is not updated on a branch grant;
  - the remaining requesters round-robin among themselves as above.
- CDB_ARB_BR_PRIORITY_EN undefined: the branch unit is an ordinary round-robin participant.

## Test plan
- Reset:
  - Stimulus: rst=1 mid-stream with req_valid=5'b11111.
  - Response: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, req_ack=0 the same cycle. After release, the first grant goes to index 0.
- Round-robin:
  - Stimulus: req_valid=5'b11111 held, cdb_ready=1 for 10 cycles.
  - Response: cdb_src sequence 0,1,2,3,4,0,1,2,3,4 (macro off). Each req_ack is one-hot, one cycle ahead of the matching cdb_src.
- Stall:
  - Stimulus: grant tag=3, data=32'hDEADBEEF; cdb_ready=0 for 3 cycles while req_valid=5'b00110.
  - Response: cdb outputs held stable, req_ack=0. On cdb_ready=1, the next grant is issued the same cycle and broadcast the following cycle.
- Flush:
  - Stimulus: cdb_valid=1, rr_ptr=3, flush=1 with cdb_ready=1 and req_valid=5'b01000.
  - Response: req_ack=0 and cdb_valid=0 next cycle. On the next grant, scanning restarts from index 0.
- Wrap and idle:
  - Stimulus: rr_ptr=4, req_valid=5'b00001.
  - Response: grant 0, rr_ptr becomes 1. Then req_valid=0 gives cdb_valid=0 on the next cycle.
- Branch priority (macro on):
  - Stimulus: req_valid=5'b10011, rr_ptr=0.
  - Response: grants are 4, 0, 1; rr_ptr stays 0 after the branch grant.
